// File: rtl/arcade_input_pkg.sv
// Shared types, joystick bit positions and small mapping helpers for arcade_input_ctrl.
package arcade_input_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } coin_state_t;

  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_START = 4;
  localparam int JOY_FIRE1 = 5;
  localparam int JOY_FIRE2 = 6;
  localparam int JOY_FIRE3 = 7;
  localparam int JOY_COIN  = 8;
  localparam int JOY_PAUSE = 9;
  localparam int JOY_AUTO  = 10;

  localparam int DIP_ADDR_W = 3;

  // fire1 arrives already resolved (active low) so autofire can be folded in by the caller.
  function automatic logic [7:0] map_port(input logic [15:0] j, input logic fire1_n);
    return {fire1_n, 1'b1, ~j[JOY_FIRE2], ~j[JOY_FIRE3],
            ~j[JOY_RIGHT], ~j[JOY_LEFT], ~j[JOY_DOWN], ~j[JOY_UP]};
  endfunction

  function automatic logic led_pwm(input logic [26:0] c);
    return c[26] ? (c[25:18] > c[7:0]) : (c[25:18] <= c[7:0]);
  endfunction

endpackage

// File: rtl/arcade_input_ctrl_coin_pulser.sv
// One coin channel: rising-edge detect, saturating pending count, IDLE/PULSE/GAP shaper.
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter logic [15:0] COIN_PULSE = 16'd50000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic coin_in,
  output logic coin_n
);

  coin_state_t r_state, w_next_state;
  logic [15:0] r_cnt, w_next_cnt;
  logic [1:0]  r_pend, w_next_pend;
  logic        r_prev, r_edge, r_coin_n;
  logic        w_take;

  // Next-state, width counter and pending bookkeeping.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_take       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend != 2'd0) begin
          w_next_state = ST_PULSE;
          w_next_cnt   = 16'd0;
          w_take       = 1'b1;
        end else begin
          w_next_cnt   = 16'd0;
        end
      end
      ST_PULSE: begin
        if (r_cnt == COIN_PULSE - 16'd1) begin
          w_next_state = ST_GAP;
          w_next_cnt   = 16'd0;
        end else begin
          w_next_cnt   = r_cnt + 16'd1;
        end
      end
      ST_GAP: begin
        // Chain straight into the next pulse so queued coins sit exactly 2*COIN_PULSE apart.
        if (r_cnt == COIN_PULSE - 16'd1) begin
          w_next_cnt = 16'd0;
          if (r_pend != 2'd0) begin
            w_next_state = ST_PULSE;
            w_take       = 1'b1;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else begin
          w_next_cnt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = 16'd0;
      end
    endcase

    if (r_edge && !w_take) begin
      w_next_pend = (r_pend == 2'd3) ? 2'd3 : r_pend + 2'd1;
    end else if (!r_edge && w_take) begin
      w_next_pend = r_pend - 2'd1;
    end else begin
      w_next_pend = r_pend;
    end
  end

  // State, counters and the registered active-low coin output.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 16'd0;
      r_pend   <= 2'd0;
      r_prev   <= 1'b0;
      r_edge   <= 1'b0;
      r_coin_n <= 1'b1;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_next_cnt;
      r_pend   <= w_next_pend;
      r_prev   <= coin_in;
      r_edge   <= coin_in & ~r_prev;
      r_coin_n <= (w_next_state != ST_PULSE);
    end
  end

  assign coin_n = r_coin_n;

endmodule

// File: rtl/arcade_input_ctrl.sv
// Player/DIP conditioning between hps_io and the game core.
// Optional autofire is enabled by defining ARCADE_INPUT_AUTOFIRE_EN.
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int          NPLAYERS   = 2,
  parameter int          NDIP       = 8,
  parameter logic [15:0] COIN_PULSE = 16'd50000,
  parameter logic [7:0]  DIP_INDEX  = 8'd254
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    ioctl_wr,
  input  logic [7:0]              ioctl_index,
  input  logic [26:0]             ioctl_addr,
  input  logic [15:0]             ioctl_dout,
  input  logic [NPLAYERS*16-1:0]  joy,
  input  logic                    osd_open,
  output logic [NPLAYERS*8-1:0]   j_out,
  output logic [NDIP*8-1:0]       dsw,
  output logic [7:0]              system,
  output logic                    pause,
  output logic                    led_user
);

  logic [15:0]         w_joy [NPLAYERS];
  logic [15:0]         w_joy1;
  logic [NPLAYERS-1:0] w_fire1_n;
  logic                w_dip_wr;
  logic                w_coin1_n, w_coin2_n;
  logic                w_unused;
  logic [26:0]         w_led_next;

  logic [7:0]            r_dsw_raw [NDIP];
  logic [NPLAYERS*8-1:0] r_j_out;
  logic                  r_start1_n, r_start2_n;
  logic                  r_pause_prev, r_pause_lat;
  logic [26:0]           r_led_cnt;
  logic                  r_led;

  genvar g;
  generate
    for (g = 0; g < NPLAYERS; g++) begin : g_joy
      assign w_joy[g] = joy[g*16 +: 16];
    end
    if (NPLAYERS > 1) begin : g_p2
      assign w_joy1 = w_joy[1];
    end else begin : g_p1
      assign w_joy1 = 16'd0;
    end
    for (g = 0; g < NDIP; g++) begin : g_dsw
      assign dsw[g*8 +: 8] = ~r_dsw_raw[g];
    end
  endgenerate

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  logic [16:0] r_af_div;
  logic        r_af_phase;

  // Shared divider; the phase flips once every 2^17 cycles.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_af_div   <= 17'd0;
      r_af_phase <= 1'b0;
    end else begin
      r_af_div <= r_af_div + 17'd1;
      if (r_af_div == 17'h1FFFF) begin
        r_af_phase <= ~r_af_phase;
      end
    end
  end

  generate
    for (g = 0; g < NPLAYERS; g++) begin : g_fire_af
      assign w_fire1_n[g] = ~(w_joy[g][JOY_FIRE1] | (w_joy[g][JOY_AUTO] & r_af_phase));
    end
  endgenerate
`else
  generate
    for (g = 0; g < NPLAYERS; g++) begin : g_fire
      assign w_fire1_n[g] = ~w_joy[g][JOY_FIRE1];
    end
  endgenerate
`endif

  assign w_dip_wr = ioctl_wr && (ioctl_index == DIP_INDEX) && (ioctl_addr[24:3] == 22'd0);

  // DIP capture; the loop bound also drops addresses at or beyond NDIP.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NDIP; i++) begin
        r_dsw_raw[i] <= 8'd0;
      end
    end else if (w_dip_wr) begin
      for (int i = 0; i < NDIP; i++) begin
        if (ioctl_addr[2:0] == DIP_ADDR_W'(i)) begin
          r_dsw_raw[i] <= ioctl_dout[7:0];
        end
      end
    end
  end

  // Cabinet ports and start buttons, one cycle behind the joystick words.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_j_out    <= {(NPLAYERS*8){1'b1}};
      r_start1_n <= 1'b1;
      r_start2_n <= 1'b1;
    end else begin
      for (int p = 0; p < NPLAYERS; p++) begin
        r_j_out[p*8 +: 8] <= map_port(w_joy[p], w_fire1_n[p]);
      end
      r_start1_n <= ~w_joy[0][JOY_START];
      r_start2_n <= ~w_joy1[JOY_START];
    end
  end

  coin_pulser #(.COIN_PULSE(COIN_PULSE)) u_coin1 (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .coin_in (w_joy[0][JOY_COIN]),
    .coin_n  (w_coin1_n)
  );

  coin_pulser #(.COIN_PULSE(COIN_PULSE)) u_coin2 (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .coin_in (w_joy1[JOY_COIN]),
    .coin_n  (w_coin2_n)
  );

  // Pause toggles on each press of player 1's pause button.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_pause_prev <= 1'b0;
      r_pause_lat  <= 1'b0;
    end else begin
      r_pause_prev <= w_joy[0][JOY_PAUSE];
      if (w_joy[0][JOY_PAUSE] && !r_pause_prev) begin
        r_pause_lat <= ~r_pause_lat;
      end
    end
  end

  assign w_led_next = r_led_cnt + 27'd1;

  // Breathing LED: registered copy of the PWM compare on the counter's next value.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_led_cnt <= 27'd0;
      r_led     <= 1'b1;
    end else begin
      r_led_cnt <= w_led_next;
      r_led     <= led_pwm(w_led_next);
    end
  end

  assign j_out    = r_j_out;
  assign system   = {3'b111, 1'b1, w_coin2_n, r_start2_n, w_coin1_n, r_start1_n};
  assign pause    = r_pause_lat | osd_open;
  assign led_user = r_led;
  assign w_unused = ^{ioctl_addr[26:25], ioctl_dout[15:8], joy};

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Scoreboard bench for arcade_input_ctrl (NPLAYERS=2, NDIP=8, COIN_PULSE=4).
module tb_arcade_input_ctrl;

  localparam int CP = 4;
  localparam int K_JOUT = 0, K_SYS = 1, K_DSW = 2, K_PAUSE = 3, K_LED = 4;

  typedef struct {
    int          cyc;
    int          kind;
    logic [63:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic [15:0] joy0, joy1;
  logic        osd_open;
  logic [15:0] j_out;
  logic [63:0] dsw;
  logic [7:0]  sys_o;
  logic        pause;
  logic        led_user;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  int   cq1[$];
  int   cq2[$];
  logic chk_done = 1'b0;
  logic drained = 1'b0;

  arcade_input_ctrl #(
    .NPLAYERS(2), .NDIP(8), .COIN_PULSE(16'd4), .DIP_INDEX(8'd254)
  ) dut (
    .clk_sys     (clk),
    .reset_n     (reset_n),
    .ioctl_wr    (ioctl_wr),
    .ioctl_index (ioctl_index),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .joy         ({joy1, joy0}),
    .osd_open    (osd_open),
    .j_out       (j_out),
    .dsw         (dsw),
    .system      (sys_o),
    .pause       (pause),
    .led_user    (led_user)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_JOUT:  return "j_out";
      K_SYS:   return "system";
      K_DSW:   return "dsw";
      K_PAUSE: return "pause";
      K_LED:   return "led_user";
      default: return "unknown";
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int c, input int k, input logic [63:0] v);
    exp_q.push_back('{cyc: c, kind: k, val: v});
  endtask

  task automatic dip_write(input logic [7:0] idx, input logic [26:0] a,
                           input logic [15:0] d, input logic [63:0] e);
    ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = a; ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
    expect_at(cyc, K_DSW, e);
  endtask

  task automatic joy_vec(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ej, input logic [7:0] es);
    joy0 = a; joy1 = b;
    tick();
    expect_at(cyc, K_JOUT, {48'd0, ej});
    expect_at(cyc, K_SYS, {56'd0, es});
  endtask

  task automatic pause_press(input int hold, input logic e);
    joy0[9] = 1'b1;
    repeat (hold) tick();
    expect_at(cyc, K_PAUSE, {63'd0, e});
    joy0[9] = 1'b0;
    tick();
  endtask

  // Monitor: pops scheduled expectations and checks every coin pulse start and width.
  initial begin : monitor
    exp_t        e;
    logic [63:0] act;
    logic        prev1 = 1'b1, prev2 = 1'b1, inp1 = 1'b0, inp2 = 1'b0;
    int          st1 = 0, st2 = 0, w;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        case (e.kind)
          K_JOUT:  act = {48'd0, j_out};
          K_SYS:   act = {56'd0, sys_o};
          K_DSW:   act = dsw;
          K_PAUSE: act = {63'd0, pause};
          K_LED:   act = {63'd0, led_user};
          default: act = 64'd0;
        endcase
        total++;
        if (act !== e.val || e.cyc != cyc) begin
          bad++;
          $display("FAIL %s cyc=%0d got=%h want=%h", kname(e.kind), cyc, act, e.val);
        end
      end
      if (!reset_n) begin
        inp1 = 1'b0; inp2 = 1'b0;
      end else begin
        if (prev1 && !sys_o[1]) begin
          total++;
          if (cq1.size() == 0) begin
            bad++; $display("FAIL coin1_unexpected cyc=%0d got=pulse want=none", cyc);
          end else begin
            w = cq1.pop_front();
            if (w != cyc) begin bad++; $display("FAIL coin1_start got=%0d want=%0d", cyc, w); end
          end
          inp1 = 1'b1; st1 = cyc;
        end else if (!prev1 && sys_o[1] && inp1) begin
          total++;
          if (cyc - st1 != CP) begin bad++; $display("FAIL coin1_width got=%0d want=%0d", cyc - st1, CP); end
          inp1 = 1'b0;
        end
        if (prev2 && !sys_o[3]) begin
          total++;
          if (cq2.size() == 0) begin
            bad++; $display("FAIL coin2_unexpected cyc=%0d got=pulse want=none", cyc);
          end else begin
            w = cq2.pop_front();
            if (w != cyc) begin bad++; $display("FAIL coin2_start got=%0d want=%0d", cyc, w); end
          end
          inp2 = 1'b1; st2 = cyc;
        end else if (!prev2 && sys_o[3] && inp2) begin
          total++;
          if (cyc - st2 != CP) begin bad++; $display("FAIL coin2_width got=%0d want=%0d", cyc - st2, CP); end
          inp2 = 1'b0;
        end
      end
      prev1 = sys_o[1];
      prev2 = sys_o[3];
      if (chk_done && !drained) begin
        total += exp_q.size() + cq1.size() + cq2.size();
        foreach (exp_q[i]) begin bad++; $display("FAIL %s_missed cyc=%0d got=none want=%h", kname(exp_q[i].kind), exp_q[i].cyc, exp_q[i].val); end
        foreach (cq1[i]) begin bad++; $display("FAIL coin1_missing got=none want=%0d", cq1[i]); end
        foreach (cq2[i]) begin bad++; $display("FAIL coin2_missing got=none want=%0d", cq2[i]); end
        drained = 1'b1;
      end
    end
  end

  // Directed stimulus; each step schedules the response it expects.
  initial begin : stimulus
    int k;
    reset_n = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'd0; ioctl_addr = 27'd0;
    ioctl_dout = 16'd0; joy0 = 16'd0; joy1 = 16'd0; osd_open = 1'b0;
    tick(); tick();
    expect_at(cyc, K_JOUT, 64'hFFFF);
    expect_at(cyc, K_SYS, 64'hFF);
    expect_at(cyc, K_DSW, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_at(cyc, K_PAUSE, 64'd0);
    expect_at(cyc, K_LED, 64'd1);
    reset_n = 1'b1;
    tick(); tick();

    dip_write(8'd254, 27'd1,         16'hC35A, 64'hFFFF_FFFF_FFFF_A5FF);
    dip_write(8'd254, 27'd9,         16'h0011, 64'hFFFF_FFFF_FFFF_A5FF);
    dip_write(8'd253, 27'd2,         16'h0033, 64'hFFFF_FFFF_FFFF_A5FF);
    dip_write(8'd254, 27'd7,         16'h000F, 64'hF0FF_FFFF_FFFF_A5FF);
    dip_write(8'd254, 27'd0,         16'h00FF, 64'hF0FF_FFFF_FFFF_A500);
    dip_write(8'd254, 27'h100_0003,  16'h0044, 64'hF0FF_FFFF_FFFF_A500);

    joy_vec(16'h0029, 16'h0000, 16'hFF76, 8'hFF);
    joy_vec(16'h0010, 16'h00C0, 16'hCFFF, 8'hFE);
    joy_vec(16'h0006, 16'h0010, 16'hFFF9, 8'hFB);
    joy_vec(16'h00E0, 16'h0039, 16'h764F, 8'hFB);
    joy_vec(16'h0410, 16'h0000, 16'hFFFF, 8'hFE);
    joy_vec(16'h0000, 16'h0000, 16'hFFFF, 8'hFF);

    pause_press(1, 1'b1);
    pause_press(3, 1'b0);
    osd_open = 1'b1;
    expect_at(cyc, K_PAUSE, 64'd1);
    pause_press(1, 1'b1);
    pause_press(1, 1'b1);
    osd_open = 1'b0;
    expect_at(cyc, K_PAUSE, 64'd0);
    tick();

    // Single coin1 held for several cycles: one credit only.
    k = cyc; cq1.push_back(k + 3);
    joy0[8] = 1'b1; repeat (5) tick(); joy0[8] = 1'b0; repeat (15) tick();

    k = cyc; cq2.push_back(k + 3);
    joy1[8] = 1'b1; tick(); joy1[8] = 1'b0; repeat (15) tick();

    // Third edge lands on the cycle the GAP hands off a pending coin.
    k = cyc; cq1.push_back(k + 3); cq1.push_back(k + 11); cq1.push_back(k + 19);
    joy0[8] = 1'b1; tick(); joy0[8] = 1'b0; repeat (3) tick();
    joy0[8] = 1'b1; tick(); joy0[8] = 1'b0; repeat (4) tick();
    joy0[8] = 1'b1; tick(); joy0[8] = 1'b0; repeat (25) tick();

    // Five edges inside one pulse: 1 immediate plus 3 saturated.
    k = cyc;
    for (int i = 0; i < 4; i++) cq1.push_back(k + 3 + 8 * i);
    for (int i = 0; i < 5; i++) begin
      joy0[8] = 1'b1; tick(); joy0[8] = 1'b0; tick();
    end
    repeat (35) tick();

    // Reset mid-pulse with one coin still pending.
    k = cyc; cq1.push_back(k + 3);
    joy0[8] = 1'b1; tick(); joy0[8] = 1'b0; tick();
    joy0[8] = 1'b1; tick(); joy0[8] = 1'b0; tick();
    tick();
    reset_n = 1'b0;
    expect_at(cyc, K_SYS, 64'hFF);
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    expect_at(cyc, K_SYS, 64'hFF);
    repeat (3) tick();
    expect_at(cyc, K_SYS, 64'hFF);
    repeat (20) tick();

    for (int i = 0; i < 50 && (exp_q.size() > 0 || cq1.size() > 0 || cq2.size() > 0); i++) tick();
    chk_done = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
